// File: rtl/rx_byte_deframer.sv
`default_nettype none
// ============================================================================
// Module   : rx_byte_deframer
// Brief    : Sync hunt, length parse, payload forward and CRC-16 check of the
//            RX byte stream. DEFRAMER_STATS_EN adds good/bad frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module rx_byte_deframer #(
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter int unsigned MAX_LEN   = 1500,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        frame_done,
    output logic        frame_ok,
`ifdef DEFRAMER_STATS_EN
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
`endif
    output logic        len_err
);

    localparam logic [15:0] c_MAX_LEN = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC_HI  = 3'd4,
        ST_CRC_LO  = 3'd5,
        ST_STATUS  = 3'd6
    } state_t;

    state_t      state_q;
    logic        ready_en_q;
    logic [15:0] sync_q;
    logic [7:0]  len_hi_q;
    logic [15:0] cnt_q;
    logic [15:0] crc_q;
    logic [15:0] rx_crc_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        m_last_q;
    logic        frame_done_q;
    logic        frame_ok_q;
    logic        len_err_q;

    logic        w_in_fire;
    logic        w_out_fire;
    logic [15:0] w_sync_next;
    logic [15:0] w_len;

    // CRC-16/CCITT, MSB-first, one byte per call
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // ready_en_q keeps s_ready low while in reset and for the first edge after it
    always_comb begin
        s_ready = 1'b0;
        if (ready_en_q) begin
            case (state_q)
                ST_PAYLOAD: s_ready = !m_valid_q || m_ready;
                ST_STATUS:  s_ready = 1'b0;
                default:    s_ready = 1'b1;
            endcase
        end
    end

    assign w_in_fire   = s_valid && s_ready;
    assign w_out_fire  = m_valid_q && m_ready;
    assign w_sync_next = {sync_q[7:0], s_data};
    assign w_len       = {len_hi_q, s_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            ready_en_q   <= 1'b0;
            sync_q       <= 16'h0000;
            len_hi_q     <= 8'h00;
            cnt_q        <= 16'h0000;
            crc_q        <= CRC_INIT;
            rx_crc_q     <= 16'h0000;
            m_data_q     <= 8'h00;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            ready_en_q   <= 1'b1;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            len_err_q    <= 1'b0;

            // A payload load later in this block overrides the drain
            if (w_out_fire) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            case (state_q)
                ST_HUNT: begin
                    if (w_in_fire) begin
                        sync_q <= w_sync_next;
                        if (w_sync_next == SYNC_WORD) state_q <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_in_fire) begin
                        len_hi_q <= s_data;
                        state_q  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_in_fire) begin
                        if (w_len == 16'd0 || w_len > c_MAX_LEN) begin
                            len_err_q <= 1'b1;
                            sync_q    <= 16'h0000;
                            state_q   <= ST_HUNT;
                        end else begin
                            crc_q   <= CRC_INIT;
                            cnt_q   <= w_len;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_in_fire) begin
                        m_data_q  <= s_data;
                        m_valid_q <= 1'b1;
                        m_last_q  <= (cnt_q == 16'd1);
                        crc_q     <= crc16_byte(crc_q, s_data);
                        cnt_q     <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) state_q <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (w_in_fire) begin
                        rx_crc_q[15:8] <= s_data;
                        state_q        <= ST_CRC_LO;
                    end
                end
                ST_CRC_LO: begin
                    if (w_in_fire) begin
                        rx_crc_q[7:0] <= s_data;
                        state_q       <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    // Status waits for the last payload byte to leave the output register
                    if (!m_valid_q) begin
                        frame_done_q <= 1'b1;
                        frame_ok_q   <= (rx_crc_q == crc_q);
                        sync_q       <= 16'h0000;
                        state_q      <= ST_HUNT;
                    end
                end
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign len_err    = len_err_q;

`ifdef DEFRAMER_STATS_EN
    logic [15:0] good_cnt_q;
    logic [15:0] bad_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= 16'h0000;
            bad_cnt_q  <= 16'h0000;
        end else begin
            if (frame_done_q && frame_ok_q && good_cnt_q != 16'hFFFF)
                good_cnt_q <= good_cnt_q + 16'd1;
            if (((frame_done_q && !frame_ok_q) || len_err_q) && bad_cnt_q != 16'hFFFF)
                bad_cnt_q <= bad_cnt_q + 16'd1;
        end
    end

    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/rx_byte_deframer.md
Name: rx_byte_deframer

Overview:
- Sits directly downstream of the RX OFDM bit-serial-to-byte converter.
- Consumes its byte stream (LSB-first assembled bytes) over a valid/ready handshake.
- Hunts for a 16-bit sync word, reads a 16-bit big-endian length, forwards exactly that many payload bytes with a last flag, then checks a trailing CRC-16 and reports frame status.
- Feeds the RX Ethernet/packet buffer stage.

Parameters:
SYNC_WORD, 16'hA55A, sync pattern; first byte on the wire = SYNC_WORD[15:8].
MAX_LEN, 1500, largest legal payload length in bytes.
CRC_INIT, 16'hFFFF, CRC-16 register init value.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_data  in  8  input byte from serial-to-parallel stage
s_valid  in  1  input byte valid
s_ready  out  1  block accepts input byte
m_data  out  8  payload byte out
m_valid  out  1  payload byte valid
m_last  out  1  marks final payload byte of frame; qualified by m_valid
m_ready  in  1  downstream accepts payload byte
frame_done  out  1  one-cycle pulse, frame status valid
frame_ok  out  1  CRC match, qualified by frame_done
len_err  out  1  one-cycle pulse, illegal length seen

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk): state=HUNT; s_ready=0; m_data=0; m_valid=0; m_last=0; frame_done=0; frame_ok=0; len_err=0; sync shift reg=0; counters=0; CRC=CRC_INIT.
- Input handshake: byte accepted when s_valid & s_ready. Output handshake: transfer when m_valid & m_ready.
- s_ready: 1 in HUNT, LEN_HI, LEN_LO, CRC_HI, CRC_LO; in PAYLOAD = !m_valid | m_ready; 0 in STATUS.
- States:
  - HUNT: shift accepted bytes into a 16-bit register {prev,cur}. When {prev,new} == SYNC_WORD -> LEN_HI. Overlapping matches allowed; e.g. A5 A5 5A matches.
  - LEN_HI: store byte as len[15:8] -> LEN_LO.
  - LEN_LO: len[7:0]=byte.
    - If len==0 or len>MAX_LEN: pulse len_err one cycle, clear the sync reg, -> HUNT. No frame_done.
    - Else: CRC=CRC_INIT, byte counter=len, -> PAYLOAD.
  - PAYLOAD: each accepted byte loads m_data, sets m_valid=1, updates CRC, decrements counter. m_last=1 when counter==1 at acceptance. After the last byte is accepted -> CRC_HI (m_valid may still be pending).
  - CRC_HI: store rx_crc[15:8] -> CRC_LO.
  - CRC_LO: rx_crc[7:0]=byte -> STATUS.
  - STATUS: hold until m_valid==0, i.e. the last payload byte has drained. Then pulse frame_done=1 for one cycle with frame_ok=(rx_crc==computed CRC), clear the sync reg, -> HUNT. frame_ok is 0 when frame_done is 0.
- Output register: m_valid clears on transfer unless a new byte loads the same cycle. m_data/m_last hold stable while m_valid & !m_ready.
- Full throughput: 1 byte/cycle in PAYLOAD with m_ready held high. Latency from input acceptance to m_valid is 1 cycle.
- CRC: CRC-16/CCITT, poly 0x1021, MSB-first per byte, no reflection, no final XOR. Covers payload only. Transmitted big-endian after payload.
- Backpressure only stalls; no byte is dropped or duplicated. s_valid low mid-frame simply waits; there is no timeout.
- Reset mid-frame: immediate return to reset values. Any pending m_valid is discarded.

Optional Feature:
- Macro DEFRAMER_STATS_EN.
- Defined: adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - good_cnt increments on frame_done & frame_ok.
  - bad_cnt increments on frame_done & !frame_ok, or on len_err.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Good frame, continuous valid, m_ready=1. Input A5 5A 00 09 "123456789" (31..39) 29 B1 -> 9 output bytes 31..39, m_last on 39 only, then frame_done=1 with frame_ok=1, len_err=0.
- Same frame with CRC bytes 29 B0 -> identical payload output; frame_done=1 with frame_ok=0.
- Garbage then sync: 00 A5 A5 5A 00 01 41 + correct CRC of 0x41 -> single byte 41 with m_last=1, frame_ok=1; leading bytes ignored.
- Illegal length: A5 5A 00 00, then separately A5 5A 05 DD -> len_err pulses twice, no m_valid, no frame_done. A following good frame is received correctly.
- Backpressure: good 9-byte frame with m_ready toggling 1 cycle high/2 low and random s_valid gaps -> payload exact and ordered, m_data stable while stalled, frame_done only after the last byte transfers.
- Reset asserted after the 4th payload byte of a frame, then released and a good frame sent -> all outputs at reset values during reset; the next frame is received correctly with frame_ok=1. With DEFRAMER_STATS_EN: good_cnt=1, bad_cnt=0.
